// File: rtl/hwag_pkg.sv
// Shared angle-generator definitions: angle width, 720-degree cycle top,
// channel count, ignition channel states and host config select codes.
package hwag_pkg;

    localparam int ACNT_WIDTH = 24;
    localparam int ANGLE_TOP  = 7679;
    localparam int CH_NUM     = 4;

    typedef logic [ACNT_WIDTH-1:0] angle_t;

    localparam angle_t ANGLE_TOP_A = ACNT_WIDTH'(ANGLE_TOP);

    localparam logic CFG_SEL_SET = 1'b0;
    localparam logic CFG_SEL_RST = 1'b1;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ARMED = 2'd1,
        DWELL = 2'd2
    } ign_state_t;

    // A window whose set angle is above its reset angle wraps through 0.
    function automatic logic in_window(angle_t a, angle_t s, angle_t r);
        if (s < r) begin
            return (a >= s) && (a < r);
        end
        return (a >= s) || (a < r);
    endfunction

endpackage

// File: rtl/ign_sched_if.sv
// Host configuration port of the ignition scheduler: one-clock write strobe
// with address/data, answered by a one-clock ack or err pulse.
interface ign_sched_if;
    import hwag_pkg::*;

    logic       cfg_wr;
    logic [2:0] cfg_addr;
    angle_t     cfg_data;
    logic       cfg_ack;
    logic       cfg_err;

    modport master (
        output cfg_wr,
        output cfg_addr,
        output cfg_data,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ack,
        output cfg_err
    );

endinterface

// File: rtl/ign_sched_channel.sv
// One ignition channel: double-buffered set/reset angles, commit/transfer
// handshake, OFF/ARMED/DWELL state machine and the raw dwell request.
module ign_channel
    import hwag_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hwag_start_i,
    input  angle_t acnt_i,
    input  logic   wr_set_i,
    input  logic   wr_rst_i,
    input  angle_t wr_data_i,
    output logic   pending_o,
    output logic   dwell_d_o
);

    angle_t     shadow_set_q, shadow_set_d;
    angle_t     shadow_rst_q, shadow_rst_d;
    angle_t     act_set_q, act_set_d;
    angle_t     act_rst_q, act_rst_d;
    logic       pending_q, pending_d;
    ign_state_t state_q, state_d;

    logic       disabled;
    logic       in_win;

    assign disabled = (act_set_q == act_rst_q);
    assign in_win   = in_window(acnt_i, act_set_q, act_rst_q);

    // Host writes land in the shadow; a committed window moves to the active
    // pair only outside DWELL and only on a clock with no competing write, so a
    // running dwell is never cut short or repeated.
    always_comb begin
        shadow_set_d = shadow_set_q;
        shadow_rst_d = shadow_rst_q;
        act_set_d    = act_set_q;
        act_rst_d    = act_rst_q;
        pending_d    = pending_q;
        state_d      = state_q;

        if (wr_set_i) begin
            shadow_set_d = wr_data_i;
        end

        if (wr_rst_i) begin
            shadow_rst_d = wr_data_i;
            pending_d    = 1'b1;
        end else if (!wr_set_i && pending_q && (state_q != DWELL)) begin
            act_set_d = shadow_set_q;
            act_rst_d = shadow_rst_q;
            pending_d = 1'b0;
        end

        case (state_q)
            OFF: begin
                if (hwag_start_i && !disabled) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!hwag_start_i || disabled) begin
                    state_d = OFF;
                end else if (acnt_i == act_set_q) begin
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (!hwag_start_i) begin
                    state_d = OFF;
                end else if (!in_win) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // Register the channel state; everything clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_set_q <= '0;
            shadow_rst_q <= '0;
            act_set_q    <= '0;
            act_rst_q    <= '0;
            pending_q    <= 1'b0;
            state_q      <= OFF;
        end else begin
            shadow_set_q <= shadow_set_d;
            shadow_rst_q <= shadow_rst_d;
            act_set_q    <= act_set_d;
            act_rst_q    <= act_rst_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
        end
    end

    assign pending_o = pending_q;
    assign dwell_d_o = (state_d == DWELL);

endmodule

// File: rtl/ign_sched.sv
// Four-channel ignition scheduler: decodes host writes, range-checks the
// angle, pulses ack/err and drives the coils with optional wasted-spark pairing.
module ign_sched
    import hwag_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hwag_start,
    input  angle_t            acnt,
    ign_sched_if.slave        cfg,
    input  logic              phased,
    output logic [CH_NUM-1:0] ch_pending,
    output logic [CH_NUM-1:0] ign_out
);

    logic              data_ok;
    logic [1:0]        wr_ch;
    logic              wr_sel;
    logic [CH_NUM-1:0] wr_set;
    logic [CH_NUM-1:0] wr_rst;
    logic [CH_NUM-1:0] dwell_d;
    logic [CH_NUM-1:0] ign_d;

    logic              ack_q;
    logic              err_q;
    logic [CH_NUM-1:0] ign_out_q;

    assign data_ok = (cfg.cfg_data <= ANGLE_TOP_A);
    assign wr_ch   = cfg.cfg_addr[2:1];
    assign wr_sel  = cfg.cfg_addr[0];

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign wr_set[i] = cfg.cfg_wr && data_ok && (wr_ch == 2'(i)) && (wr_sel == CFG_SEL_SET);
        assign wr_rst[i] = cfg.cfg_wr && data_ok && (wr_ch == 2'(i)) && (wr_sel == CFG_SEL_RST);

        ign_channel u_ch (
            .clk          (clk),
            .rst          (rst),
            .hwag_start_i (hwag_start),
            .acnt_i       (acnt),
            .wr_set_i     (wr_set[i]),
            .wr_rst_i     (wr_rst[i]),
            .wr_data_i    (cfg.cfg_data),
            .pending_o    (ch_pending[i]),
            .dwell_d_o    (dwell_d[i])
        );
    end

    // In phased mode each coil also fires with its partner two channels away.
    assign ign_d = dwell_d | ({CH_NUM{phased}} & {dwell_d[1:0], dwell_d[3:2]});

    // Write response pulses and the coil drive register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ign_out_q <= '0;
        end else begin
            ack_q     <= cfg.cfg_wr && data_ok;
            err_q     <= cfg.cfg_wr && !data_ok;
            ign_out_q <= ign_d;
        end
    end

    assign cfg.cfg_ack = ack_q;
    assign cfg.cfg_err = err_q;
    assign ign_out     = ign_out_q;

endmodule

// File: tb/tb_ign_sched.sv
// Self-checking bench for ign_sched: a config vector table, then hand-built
// angle sweeps covering plain, wrapped, deferred-commit, resync, phased and
// reset-mid-dwell behaviour. Expectations go through a scoreboard queue.
module tb_ign_sched;
    import hwag_pkg::*;

    typedef struct packed {
        logic [3:0] ign;
        logic [3:0] pend;
        logic       ack;
        logic       err;
    } exp_t;

    typedef struct {
        bit         wr;
        bit [2:0]   addr;
        int         data;
        logic [3:0] eIgn;
        logic [3:0] ePend;
        bit         eAck;
        bit         eErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hwag_start = 1'b0;
    angle_t      acnt = '0;
    logic        phased = 1'b0;
    logic [3:0]  ch_pending;
    logic [3:0]  ign_out;

    ign_sched_if cfg_bus ();

    exp_t sbQ[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   highCount0;
    int   highCount2;
    vec_t vecs[8];

    ign_sched dut (
        .clk        (clk),
        .rst        (rst),
        .hwag_start (hwag_start),
        .acnt       (acnt),
        .cfg        (cfg_bus),
        .phased     (phased),
        .ch_pending (ch_pending),
        .ign_out    (ign_out)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic compareField(input string name, input string field, input logic [3:0] got, input logic [3:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s %s got %h expected %h at acnt %0d", name, field, got, want, acnt);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sbQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s scoreboard empty", name);
        end else begin
            e = sbQ.pop_front();
            compareField(name, "ign_out", ign_out, e.ign);
            compareField(name, "ch_pending", ch_pending, e.pend);
            compareField(name, "cfg_ack", {3'b0, cfg_bus.cfg_ack}, {3'b0, e.ack});
            compareField(name, "cfg_err", {3'b0, cfg_bus.cfg_err}, {3'b0, e.err});
        end
    endtask

    task automatic applyStimulus(input int a, input bit hw, input bit wr, input bit [2:0] addr, input int data,
                                 input logic [3:0] eIgn, input logic [3:0] ePend, input bit eAck, input bit eErr,
                                 input string name);
        exp_t e;
        acnt             = ACNT_WIDTH'(a);
        hwag_start       = hw;
        cfg_bus.cfg_wr   = wr;
        cfg_bus.cfg_addr = addr;
        cfg_bus.cfg_data = ACNT_WIDTH'(data);
        e.ign  = eIgn;
        e.pend = ePend;
        e.ack  = eAck;
        e.err  = eErr;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        cfg_bus.cfg_wr = 1'b0;
        checkOutput(name);
    endtask

    task automatic step(input int a, input bit hw, input logic [3:0] eIgn, input logic [3:0] ePend, input string name);
        applyStimulus(a, hw, 1'b0, 3'b000, 0, eIgn, ePend, 1'b0, 1'b0, name);
    endtask

    initial begin
        logic e0, e1, e2, p2;

        cfg_bus.cfg_wr   = 1'b0;
        cfg_bus.cfg_addr = 3'b000;
        cfg_bus.cfg_data = '0;

        vecs[0] = '{1'b1, 3'b000, 1152, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 3'b001, 1216, 4'b0000, 4'b0001, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 3'b000, 0,    4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 3'b000, 7680, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 3'b001, 7680, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 3'b110, 7679, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 3'b111, 7679, 4'b0000, 4'b1000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 3'b000, 0,    4'b0000, 4'b0000, 1'b0, 1'b0};

        rst = 1'b1;
        step(0, 1'b0, 4'b0000, 4'b0000, "reset");
        step(0, 1'b1, 4'b0000, 4'b0000, "reset_hw");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data,
                          vecs[i].eIgn, vecs[i].ePend, vecs[i].eAck, vecs[i].eErr,
                          $sformatf("cfg_vec%0d", i));
        end

        highCount0 = 0;
        for (int a = 0; a <= ANGLE_TOP; a++) begin
            e0 = (a >= 1152) && (a <= 1215);
            step(a, 1'b1, {3'b000, e0}, 4'b0000, "sweep_ch0");
            if (ign_out[0]) highCount0++;
        end
        compareField("dwell_len_ch0", "clks", 4'(highCount0 == 64), 4'd1);

        applyStimulus(0, 1'b1, 1'b1, 3'b010, 7600, 4'b0000, 4'b0000, 1'b1, 1'b0, "ch1_set");
        applyStimulus(1, 1'b1, 1'b1, 3'b011, 100,  4'b0000, 4'b0010, 1'b1, 1'b0, "ch1_rst");
        step(2, 1'b1, 4'b0000, 4'b0000, "ch1_xfer");
        for (int a = 7590; a <= ANGLE_TOP; a++) begin
            e1 = (a >= 7600);
            step(a, 1'b1, {2'b00, e1, 1'b0}, 4'b0000, "wrap_ch1_hi");
        end
        for (int a = 0; a <= 110; a++) begin
            e1 = (a <= 99);
            step(a, 1'b1, {2'b00, e1, 1'b0}, 4'b0000, "wrap_ch1_lo");
        end

        applyStimulus(111, 1'b1, 1'b1, 3'b010, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, "ch1_dis_set");
        applyStimulus(112, 1'b1, 1'b1, 3'b011, 0, 4'b0000, 4'b0010, 1'b1, 1'b0, "ch1_dis_rst");
        step(113, 1'b1, 4'b0000, 4'b0000, "ch1_dis_xfer");

        applyStimulus(114, 1'b1, 1'b1, 3'b100, 4992, 4'b0000, 4'b0000, 1'b1, 1'b0, "ch2_set");
        applyStimulus(115, 1'b1, 1'b1, 3'b101, 5056, 4'b0000, 4'b0100, 1'b1, 1'b0, "ch2_rst");
        step(116, 1'b1, 4'b0000, 4'b0000, "ch2_xfer");
        step(117, 1'b1, 4'b0000, 4'b0000, "ch2_arm");
        for (int a = 4980; a <= 6200; a++) begin
            e2 = ((a >= 4992) && (a <= 5055)) || ((a >= 6000) && (a <= 6099));
            p2 = (a >= 5000) && (a <= 5056);
            if (a == 4999) begin
                applyStimulus(a, 1'b1, 1'b1, 3'b100, 6000, {1'b0, e2, 2'b00}, {1'b0, p2, 2'b00}, 1'b1, 1'b0, "ch2_dwell_set");
            end else if (a == 5000) begin
                applyStimulus(a, 1'b1, 1'b1, 3'b101, 6100, {1'b0, e2, 2'b00}, {1'b0, p2, 2'b00}, 1'b1, 1'b0, "ch2_dwell_commit");
            end else begin
                step(a, 1'b1, {1'b0, e2, 2'b00}, {1'b0, p2, 2'b00}, "ch2_deferred");
            end
        end

        for (int a = 1140; a <= 1179; a++) begin
            e0 = (a >= 1152);
            step(a, 1'b1, {3'b000, e0}, 4'b0000, "resync_pre");
        end
        for (int a = 1180; a <= 1189; a++) begin
            step(a, 1'b0, 4'b0000, 4'b0000, "hwag_drop");
        end
        for (int a = 1190; a <= ANGLE_TOP; a++) begin
            e2 = (a >= 6000) && (a <= 6099);
            step(a, 1'b1, {1'b0, e2, 2'b00}, 4'b0000, "resync_run");
        end
        for (int a = 0; a <= 1220; a++) begin
            e0 = (a >= 1152) && (a <= 1215);
            step(a, 1'b1, {3'b000, e0}, 4'b0000, "resync_next");
        end

        phased = 1'b1;
        highCount2 = 0;
        for (int a = 1140; a <= 1230; a++) begin
            e0 = (a >= 1152) && (a <= 1215);
            step(a, 1'b1, {1'b0, e0, 1'b0, e0}, 4'b0000, "phased");
            if (ign_out[2]) highCount2++;
        end
        compareField("dwell_len_ch2_phased", "clks", 4'(highCount2 == 64), 4'd1);

        for (int a = 1140; a <= 1160; a++) begin
            e0 = (a >= 1152);
            step(a, 1'b1, {1'b0, e0, 1'b0, e0}, 4'b0000, "pre_rst");
        end
        rst = 1'b1;
        step(1161, 1'b1, 4'b0000, 4'b0000, "rst_mid_dwell");
        rst = 1'b0;
        step(1162, 1'b1, 4'b0000, 4'b0000, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/ign_sched.md
# ign_sched

Ignition channel scheduler for the angle generator. It consumes the synchronized 720° angle count (acnt3 domain, 0..7679) and drives four coil outputs between a programmable set angle (dwell start) and reset angle (spark). Angles are held in double-buffered per-channel registers written by the host. A channel's new window takes effect only at a safe point, so no dwell is ever truncated or doubled. It sits after the cam-synchronized slave angle counter and replaces fixed-constant set/reset comparators.

## Interface
- ACNT_WIDTH, 24, angle count width
- ANGLE_TOP, 7679, last angle count of the 720° cycle
- CH_NUM, 4, number of ignition channels (fixed at 4 for this revision)

- clk  in  1  module clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- hwag_start  in  1  angle generator synchronized; low = acnt invalid
- acnt  in  ACNT_WIDTH  current angle, 0..ANGLE_TOP, steps by at most 1 per clk except on resync
- cfg_wr  in  1  host write strobe, one clk
- cfg_addr  in  3  {channel[1:0], sel}; sel 0 = set angle, 1 = reset angle
- cfg_data  in  ACNT_WIDTH  angle value
- cfg_ack  out  1  write accepted, one-clk pulse
- cfg_err  out  1  write rejected (cfg_data > ANGLE_TOP), one-clk pulse
- phased  in  1  1 = wasted-spark pairing (ch0|ch2, ch1|ch3)
- ch_pending  out  CH_NUM  shadow committed but not yet active, per channel
- ign_out  out  CH_NUM  coil drive, 1 = dwell

## Operation
- Per channel: shadow_set, shadow_rst, act_set, act_rst, pending, 2-bit state.
- Write with sel=0 updates shadow_set only. Write with sel=1 updates shadow_rst and sets pending (commit). Host writes set, then reset.
- cfg_data > ANGLE_TOP: no register changes, cfg_err=1, cfg_ack=0.
- Transfer: when pending and state != DWELL, act_* <= shadow_*, pending cleared.
- Window: in_win = (act_set < act_rst) ? (acnt >= act_set && acnt < act_rst) : (acnt >= act_set || acnt < act_rst). The second case is a window wrapping through 0.
- States:
  - OFF: output 0. Go to ARMED when hwag_start=1 and act_set != act_rst.
  - ARMED: output 0. Go to DWELL when acnt == act_set. Equality only, so there is no partial dwell after sync or after a transfer.
  - DWELL: output 1. Go to ARMED when in_win=0. This covers both a normal reset and an acnt jump out of the window.
- act_set == act_rst disables the channel: state goes to OFF from ARMED or OFF. A channel in DWELL finishes its dwell first.
- hwag_start=0 in any state: OFF next clk, and ign_out cleared the same edge.
- ign_out[i] = q[i] | (phased & q[(i+2)%4]), registered.

## Timing
- Reset: all state OFF; act_*, shadow_*, pending = 0; ign_out, cfg_ack, cfg_err, ch_pending = 0.
- cfg_ack / cfg_err: asserted the clk after cfg_wr.
- Transfer: completes the clk after the commit when not in DWELL. When in DWELL, it completes the clk after the DWELL→ARMED edge.
- ign_out latency: 1 clk from acnt == act_set (rise) and from in_win falling (fall).
- Simultaneous write and transfer in the same clk: the write wins. Shadow updates, pending stays 1, and the transfer happens the following clk with the new data.
- Commit during DWELL: act_* are untouched until that dwell ends. The new window is first evaluated in ARMED.
- acnt wrap ANGLE_TOP→0: no special event. The wrapped-window formula handles it.
- rst mid-dwell: ign_out 0 on the next edge.

## Structure
- Shared package hwag_pkg: ACNT_WIDTH, ANGLE_TOP (7679), ign_state_t enum {OFF, ARMED, DWELL}, CFG_SEL_SET/CFG_SEL_RST constants.
- One sub-module, ign_channel. It holds the shadow/active registers, pending, FSM, window compare and raw output, and is instantiated 4×.
- The top level handles address decode, range check, ack/err pulses and phased OR-ing.

## Test plan
- Window 1152/1216 on ch0, hwag_start=1, acnt sweeps 0..7679 → ign_out[0] high for acnt 1153..1216 (1-clk lag). It is high for exactly 64 clks per cycle and the other channels stay 0.
- Wrapped window ch1 set=7600, rst=100, sweep through wrap → ign_out[1] high continuously from 7601 across 0 through 100, then low.
- Commit ch2 rst during DWELL at acnt=5000 with window 4992/5056, new 6000/6100 → the current dwell ends at 5056. ch_pending=1 until 5057, and the next dwell is at 6000.
- hwag_start drops at acnt=1180 mid-dwell → ign_out[0]=0 next clk, and state OFF. After resync with acnt restarting at 1190, there is no dwell until acnt==1152 of the next cycle.
- cfg_wr data=7680 → cfg_err pulse, no ack, registers unchanged. data=7679 → ack.
- phased=1, ch0 window only → ign_out[0] and ign_out[2] pulse identically.
